// File: rtl/lap_recorder_if.sv
// Output stream of lap_recorder: head entry plus valid/ready handshake.
interface lap_recorder_if #(
   parameter int DATA_WIDTH = 16
);
   logic [DATA_WIDTH-1:0] dout;
   logic                  dout_valid;
   logic                  dout_ready;

   modport master (output dout, output dout_valid, input dout_ready);
   modport slave  (input dout, input dout_valid, output dout_ready);
endinterface

// File: rtl/lap_recorder.sv
// Lap capture into a show-ahead FIFO drained over valid/ready.
// Build option LAP_RECORDER_SPLIT_EN stores split times (delta since previous lap) instead of absolute counts.
module lap_recorder #(
   parameter int DATA_WIDTH = 16,
   parameter int MAX        = 99,
   parameter int DEPTH      = 4
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic [DATA_WIDTH-1:0]    count,
   input  logic                     lap,
   input  logic                     clear,
   lap_recorder_if.master           drain,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic [1:0] {
      OCC_EMPTY,
      OCC_PARTIAL,
      OCC_FULL
   } occ_t;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         rd_ptr;
   logic [AW-1:0]         wr_ptr;
   logic [LW-1:0]         level_q;
   logic [LW-1:0]         level_nxt;
   logic                  full_q;
   logic                  overflow_q;
   logic [DATA_WIDTH-1:0] push_val;
   occ_t                  occ;
   logic                  pop;
   logic                  push;
   logic                  drop;

   always_comb begin
      occ = OCC_PARTIAL;
      if (level_q == '0)
         occ = OCC_EMPTY;
      else if (level_q == LW'(DEPTH))
         occ = OCC_FULL;
   end

   // A full FIFO still accepts a lap when the head leaves in the same cycle.
   always_comb begin
      pop  = (occ != OCC_EMPTY) && drain.dout_ready;
      push = lap && ((occ != OCC_FULL) || pop);
      drop = lap && (occ == OCC_FULL) && !pop;
   end

   always_comb begin
      level_nxt = level_q;
      case ({push, pop})
         2'b10:   level_nxt = level_q + LW'(1);
         2'b01:   level_nxt = level_q - LW'(1);
         default: level_nxt = level_q;
      endcase
   end

`ifdef LAP_RECORDER_SPLIT_EN
   localparam logic [DATA_WIDTH:0] MODULUS = (DATA_WIDTH+1)'(MAX + 1);

   logic [DATA_WIDTH-1:0] prev_q;

   // Delta computed one bit wider so the wrap term cannot overflow before truncation.
   always_comb begin
      push_val = '0;
      if (count >= prev_q)
         push_val = count - prev_q;
      else
         push_val = DATA_WIDTH'({1'b0, count} + MODULUS - {1'b0, prev_q});
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         prev_q <= '0;
      else if (clear)
         prev_q <= '0;
      else if (lap)
         prev_q <= count;
   end
`else
   always_comb begin
      push_val = count;
   end
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         level_q    <= '0;
         full_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else if (clear) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         level_q    <= '0;
         full_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         level_q    <= level_nxt;
         full_q     <= (level_nxt == LW'(DEPTH));
         overflow_q <= overflow_q | drop;
      end
   end

   always_ff @(posedge clk) begin
      if (!clear && push)
         mem[wr_ptr] <= push_val;
   end

   always_comb begin
      drain.dout_valid = (occ != OCC_EMPTY);
      drain.dout       = (occ != OCC_EMPTY) ? mem[rd_ptr] : '0;
      level            = level_q;
      full             = full_q;
      overflow         = overflow_q;
   end

   count_in_range: assert property (@(posedge clk) disable iff (!resetn)
      count <= DATA_WIDTH'(MAX));

endmodule

// File: tb/tb_lap_recorder.sv
// Scoreboard bench for lap_recorder: stimulus queues expected entries, a negedge monitor checks each pop.
module tb_lap_recorder;

   localparam int DW    = 16;
   localparam int DEPTH = 4;
   localparam int LW    = 3;
`ifdef LAP_RECORDER_SPLIT_EN
   localparam bit SPLIT = 1'b1;
`else
   localparam bit SPLIT = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic [DW-1:0] count = '0;
   logic          lap = 1'b0;
   logic          clear = 1'b0;
   logic [LW-1:0] level;
   logic          full;
   logic          overflow;

   int            total = 0;
   int            bad = 0;
   logic [DW-1:0] exp_q [$];

   lap_recorder_if #(.DATA_WIDTH(DW)) drain_if ();

   lap_recorder #(.DATA_WIDTH(DW), .MAX(99), .DEPTH(DEPTH)) dut (
      .clk      (clk),
      .resetn   (resetn),
      .count    (count),
      .lap      (lap),
      .clear    (clear),
      .drain    (drain_if.master),
      .level    (level),
      .full     (full),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      total++;
      if (act !== exp_v) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
      end
   endtask

   function automatic logic [DW-1:0] sel(input logic [DW-1:0] abs_v, input logic [DW-1:0] split_v);
      return SPLIT ? split_v : abs_v;
   endfunction

   // Monitor: a pop happens on the next rising edge whenever valid and ready are both high here.
   always @(negedge clk) begin
      if (resetn && !clear && drain_if.dout_valid && drain_if.dout_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_pop: got %0d expected none", drain_if.dout);
         end else begin
            check("pop_data", 32'(drain_if.dout), 32'(exp_q.pop_front()));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_lap(input logic [DW-1:0] c, input bit accepted, input logic [DW-1:0] exp_v);
      count = c;
      lap   = 1'b1;
      step();
      lap   = 1'b0;
      if (accepted)
         exp_q.push_back(exp_v);
   endtask

   task automatic do_clear();
      clear = 1'b1;
      step();
      clear = 1'b0;
      exp_q.delete();
   endtask

   task automatic fill4();
      do_lap(16'd1, 1'b1, sel(16'd1, 16'd1));
      do_lap(16'd2, 1'b1, sel(16'd2, 16'd1));
      do_lap(16'd3, 1'b1, sel(16'd3, 16'd1));
      do_lap(16'd4, 1'b1, sel(16'd4, 16'd1));
   endtask

   task automatic drain_all();
      bit done;
      done = 1'b0;
      drain_if.dout_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         if (!drain_if.dout_valid) begin
            done = 1'b1;
            break;
         end
      end
      drain_if.dout_ready = 1'b0;
      check("drain_done", 32'(done), 32'd1);
      check("sb_empty", 32'(exp_q.size()), 32'd0);
      check("dout_idle", 32'(drain_if.dout), 32'd0);
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_valid"}, 32'(drain_if.dout_valid), 32'd0);
      check({tag, "_level"}, 32'(level), 32'd0);
      check({tag, "_full"}, 32'(full), 32'd0);
      check({tag, "_overflow"}, 32'(overflow), 32'd0);
      check({tag, "_dout"}, 32'(drain_if.dout), 32'd0);
   endtask

   initial begin
      drain_if.dout_ready = 1'b0;
      #3;
      check_idle("por");
      #9 resetn = 1'b1;
      step();

      // Asynchronous reset in the middle of a drain
      do_lap(16'd10, 1'b1, sel(16'd10, 16'd10));
      do_lap(16'd20, 1'b1, sel(16'd20, 16'd10));
      do_lap(16'd30, 1'b1, sel(16'd30, 16'd10));
      check("t1_level3", 32'(level), 32'd3);
      drain_if.dout_ready = 1'b1;
      step();
      #2 resetn = 1'b0;
      exp_q.delete();
      #1;
      check_idle("t1_reset");
      drain_if.dout_ready = 1'b0;
      #3 resetn = 1'b1;
      step();
      do_lap(16'd7, 1'b1, 16'd7);
      check("t1_first_valid", 32'(drain_if.dout_valid), 32'd1);
      check("t1_first_dout", 32'(drain_if.dout), 32'd7);
      drain_all();

      // Basic capture, head held while not ready
      do_clear();
      do_lap(16'd5, 1'b1, 16'd5);
      do_lap(16'd12, 1'b1, sel(16'd12, 16'd7));
      check("t2_level", 32'(level), 32'd2);
      step();
      check("t2_hold_head", 32'(drain_if.dout), 32'd5);
      check("t2_hold_valid", 32'(drain_if.dout_valid), 32'd1);
      drain_all();

      // Overflow
      do_clear();
      fill4();
      check("t3_full", 32'(full), 32'd1);
      check("t3_level4", 32'(level), 32'd4);
      check("t3_no_ovf", 32'(overflow), 32'd0);
      do_lap(16'd5, 1'b0, 16'd0);
      check("t3_overflow", 32'(overflow), 32'd1);
      check("t3_level_kept", 32'(level), 32'd4);
      drain_all();
      check("t3_ovf_sticky", 32'(overflow), 32'd1);

      // Push and pop together while full
      do_clear();
      check("t4_ovf_cleared", 32'(overflow), 32'd0);
      fill4();
      drain_if.dout_ready = 1'b1;
      do_lap(16'd9, 1'b1, sel(16'd9, 16'd5));
      drain_if.dout_ready = 1'b0;
      check("t4_level", 32'(level), 32'd4);
      check("t4_full", 32'(full), 32'd1);
      check("t4_overflow", 32'(overflow), 32'd0);
      drain_all();

      // Split wrap across MAX
      do_clear();
      do_lap(16'd95, 1'b1, 16'd95);
      do_lap(16'd3, 1'b1, sel(16'd3, 16'd8));
      do_lap(16'd3, 1'b1, sel(16'd3, 16'd0));
      check("t5_level", 32'(level), 32'd3);
      drain_all();

      // Clear beats lap and pop in the same cycle
      do_clear();
      fill4();
      do_lap(16'd5, 1'b0, 16'd0);
      check("t6_overflow", 32'(overflow), 32'd1);
      drain_if.dout_ready = 1'b1;
      step();
      drain_if.dout_ready = 1'b0;
      check("t6_level3", 32'(level), 32'd3);
      clear = 1'b1;
      lap   = 1'b1;
      count = 16'd50;
      drain_if.dout_ready = 1'b1;
      step();
      clear = 1'b0;
      lap   = 1'b0;
      drain_if.dout_ready = 1'b0;
      exp_q.delete();
      check_idle("t6_clear");
      do_lap(16'd40, 1'b1, 16'd40);
      check("t6_after_clear", 32'(drain_if.dout), 32'd40);
      drain_all();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
